// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding and constants shared by the UART receive frame controller.
package uart_rx_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int BIT_CNT_W = 4;

    function automatic logic parity_bit(input logic [7:0] d, input logic typ);
        return (typ == PAR_EVEN) ? ^d : ~^d;
    endfunction
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversample edge counter and data bit counter for the RX frame FSM.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 bit_en_i,
    input  logic [5:0]           prescale_i,
    output logic [4:0]           edge_cnt_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o,
    output logic                 wrap_o
);
    logic [4:0] edge_q, edge_d, last;
    logic [5:0] presc_m1;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;

    always_comb begin
        presc_m1 = prescale_i - 6'd1;
        // Truncating to 5 bits keeps the wrap reachable for any prescale value.
        last = presc_m1[4:0];
        wrap_o = edge_q == last;
        edge_d = (en_i && !wrap_o) ? edge_q + 5'd1 : 5'd0;
        bit_d = !bit_en_i ? '0 : wrap_o ? bit_q + BIT_CNT_W'(1) : bit_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; detects start, deserializes LSB-first,
// and checks parity and stop using the external 3-sample majority sampler.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    input  logic                  sampling_done,
    output logic                  data_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [5:0]            samp_prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
    logic [5:0] presc_q, presc_d;
    logic par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic par_mis_q, par_mis_d, stop_bad_q, stop_bad_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic wrap, frame_end, start, cnt_en;

    uart_rx_edge_bit_cnt u_cnt (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .en_i       (cnt_en),
        .bit_en_i   (state_q == ST_DATA),
        .prescale_i (presc_q),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .wrap_o     (wrap)
    );

    always_comb begin
        frame_end = state_q == ST_STOP && wrap;
        // A low line in the frame-end cycle chains straight into the next start bit.
        start = !RX_IN && (state_q == ST_IDLE || frame_end);
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = start ? ST_START : ST_IDLE;
            ST_START:  state_d = (sampling_done && sampled_bit) ? ST_IDLE : wrap ? ST_DATA : ST_START;
            ST_DATA:   state_d = (wrap && bit_cnt == LAST_BIT) ? (par_en_q ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY: state_d = wrap ? ST_STOP : ST_PARITY;
            ST_STOP:   state_d = wrap ? (start ? ST_START : ST_IDLE) : ST_STOP;
            default:   state_d = ST_IDLE;
        endcase
        cnt_en = state_q != ST_IDLE && state_d != ST_IDLE;
        presc_d = start ? Prescale : presc_q;
        par_en_d = start ? PAR_EN : par_en_q;
        par_typ_d = start ? PAR_TYP : par_typ_q;
        shift_d = (state_q == ST_DATA && sampling_done) ? {sampled_bit, shift_q[DATA_WIDTH-1:1]} : shift_q;
        par_mis_d = start ? 1'b0 :
                    (state_q == ST_PARITY && sampling_done) ? sampled_bit ^ parity_bit(8'(shift_q), par_typ_q) :
                    par_mis_q;
        stop_bad_d = start ? 1'b0 : (state_q == ST_STOP && sampling_done) ? ~sampled_bit : stop_bad_q;
        data_valid = frame_end && !par_mis_q && !stop_bad_q;
        par_err = frame_end && par_mis_q;
        stp_err = frame_end && stop_bad_q;
        pdata_d = data_valid ? shift_q : pdata_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            pdata_q    <= '0;
            presc_q    <= PRESC_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_mis_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pdata_q    <= pdata_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_mis_q  <= par_mis_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    assign busy          = state_q != ST_IDLE;
    assign data_samp_en  = busy;
    assign samp_prescale = presc_q;
    assign P_DATA        = pdata_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: frame-level bench with a behavioural majority sampler and a per-cycle
// expectation derived from bit positions, frame length and the parity/stop rules.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [5:0] presc;
        logic       pe, pt, pflip, sbit, chain;
        int         glitch, abort_at;
        logic       exp_dv, exp_pe, exp_se;
        int         exp_last;
    } frame_t;

    logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic sampled_bit, sampling_done, data_samp_en, data_valid, par_err, stp_err, busy;
    logic [4:0] edge_cnt, half;
    logic [5:0] samp_prescale;
    logic [7:0] P_DATA;
    logic s0 = 1'b1, s1 = 1'b1, s2 = 1'b1;
    int vec = 0, bad = 0;
    logic [7:0] pdata_exp = 8'h00;
    logic [5:0] presc_exp = 6'd8;

    always #5 CLK = ~CLK;

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .sampling_done(sampling_done),
        .data_samp_en(data_samp_en), .edge_cnt(edge_cnt), .samp_prescale(samp_prescale),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    // Sampler: votes over the three positions around mid-bit, strobes two positions later.
    assign half = samp_prescale[5:1];
    always @(posedge CLK) begin
        if (data_samp_en && edge_cnt == half - 5'd1) s0 <= RX_IN;
        if (data_samp_en && edge_cnt == half) s1 <= RX_IN;
        if (data_samp_en && edge_cnt == half + 5'd1) s2 <= RX_IN;
    end
    assign sampling_done = data_samp_en && edge_cnt == half + 5'd2;
    assign sampled_bit = (s0 & s1) | (s0 & s2) | (s1 & s2);

    function automatic logic [23:0] pack(input logic b, en, input logic [4:0] e, input logic [5:0] p,
                                         input logic dv, pe, se, input logic [7:0] d);
        return {b, en, e, p, dv, pe, se, d};
    endfunction

    task automatic cmp(input string name, input logic [23:0] exp);
        logic [23:0] got;
        got = pack(busy, data_samp_en, edge_cnt, samp_prescale, data_valid, par_err, stp_err, P_DATA);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got busy=%b en=%b edge=%0d presc=%0d dv=%b perr=%b serr=%b pdata=%h; expected busy=%b en=%b edge=%0d presc=%0d dv=%b perr=%b serr=%b pdata=%h",
                     name, vec, got[23], got[22], got[21:17], got[16:11], got[10], got[9], got[8], got[7:0],
                     exp[23], exp[22], exp[21:17], exp[16:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic [5:0] p, input logic pe, pt, pflip, sbit, chain,
                                  input int glitch, abort_at, input logic dv, perr, serr, input int last);
        frame_t f;
        f.data = d; f.presc = p; f.pe = pe; f.pt = pt; f.pflip = pflip; f.sbit = sbit; f.chain = chain;
        f.glitch = glitch; f.abort_at = abort_at; f.exp_dv = dv; f.exp_pe = perr; f.exp_se = serr; f.exp_last = last;
        return f;
    endfunction

    // Reference outcome of a clean frame: errors from the line contents, end at the last oversample of the stop bit.
    function automatic frame_t rnd(input logic chain);
        logic [7:0] d;
        logic [5:0] p;
        logic pe, pt, pflip, sbit, perr, serr;
        int r;
        d = 8'($urandom);
        r = $urandom_range(2);
        p = (r == 0) ? PRESC_8 : (r == 1) ? PRESC_16 : PRESC_32;
        pe = 1'($urandom); pt = 1'($urandom);
        pflip = $urandom_range(3) == 0;
        sbit = $urandom_range(3) != 0;
        perr = pe && pflip;
        serr = !sbit;
        return mk(d, p, pe, pt, pflip, sbit, chain, 0, -1, !perr && !serr, perr, serr, (10 + int'(pe)) * int'(p) - 1);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cmp("idle", pack(1'b0, 1'b0, 5'd0, presc_exp, 1'b0, 1'b0, 1'b0, pdata_exp));
        end
    endtask

    // Entered at a falling edge one cycle before the start edge is registered.
    task automatic run(input frame_t f);
        logic [11:0] bits;
        int nb, p, idx, k;
        logic aborted;
        p = int'(f.presc);
        nb = 10 + int'(f.pe);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = f.data[i];
        if (f.pe) bits[9] = (^f.data) ^ f.pt ^ f.pflip;
        bits[nb - 1] = f.sbit;
        Prescale = f.presc; PAR_EN = f.pe; PAR_TYP = f.pt; RX_IN = 1'b0;
        aborted = 1'b0;
        k = 0;
        while (k <= f.exp_last && !aborted) begin
            @(negedge CLK);
            if (k == f.abort_at) begin
                RST = 1'b0; RX_IN = 1'b1;
                #1;
                pdata_exp = 8'h00; presc_exp = PRESC_8;
                cmp("async reset", pack(1'b0, 1'b0, 5'd0, PRESC_8, 1'b0, 1'b0, 1'b0, 8'h00));
                @(negedge CLK);
                RST = 1'b1;
                aborted = 1'b1;
            end else begin
                cmp("frame", pack(1'b1, 1'b1, 5'(k % p), f.presc, k == f.exp_last && f.exp_dv,
                                  k == f.exp_last && f.exp_pe, k == f.exp_last && f.exp_se, pdata_exp));
                Prescale = 6'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
                idx = (k + 1) / p;
                if (f.glitch > 0) RX_IN = (k + 1) >= f.glitch;
                else RX_IN = (idx < nb) ? bits[idx] : !f.chain;
                k++;
            end
        end
        if (!aborted) begin
            presc_exp = f.presc;
            if (f.exp_dv) pdata_exp = f.data;
        end
    endtask

    initial begin
        frame_t tbl[$];
        tbl.push_back(mk(8'hA5, 6'd8,  1, 0, 0, 1, 0, 0, -1, 1, 0, 0, 87));
        tbl.push_back(mk(8'hA5, 6'd8,  1, 0, 1, 1, 0, 0, -1, 0, 1, 0, 87));
        tbl.push_back(mk(8'h3C, 6'd16, 0, 0, 0, 0, 0, 0, -1, 0, 0, 1, 159));
        tbl.push_back(mk(8'h00, 6'd8,  0, 0, 0, 1, 0, 2, -1, 0, 0, 0, 6));
        tbl.push_back(mk(8'h01, 6'd32, 1, 1, 0, 1, 1, 0, -1, 1, 0, 0, 351));
        tbl.push_back(mk(8'hFF, 6'd32, 1, 1, 0, 1, 0, 0, -1, 1, 0, 0, 351));
        tbl.push_back(mk(8'h55, 6'd8,  0, 0, 0, 1, 0, 0, 30, 0, 0, 0, 79));
        tbl.push_back(mk(8'h55, 6'd8,  0, 0, 0, 1, 0, 0, -1, 1, 0, 0, 79));
        tbl.push_back(mk(8'hC3, 6'd16, 1, 1, 1, 0, 0, 0, -1, 0, 1, 1, 175));
        for (int i = 0; i < 24; i++) tbl.push_back(rnd(i != 23 && $urandom_range(1) == 1));
        repeat (2) @(negedge CLK);
        cmp("reset values", pack(1'b0, 1'b0, 5'd0, 6'd8, 1'b0, 1'b0, 1'b0, 8'h00));
        RST = 1'b1;
        idle(2);
        foreach (tbl[i]) begin
            run(tbl[i]);
            if (!tbl[i].chain) idle(2);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
